// File: rtl/maxnet_pu.sv
// N-channel MaxNet winner-take-all unit: loads a ReLU'd vector, then repeats
// lateral inhibition until at most one channel survives or MAX_ITER is hit.
module maxnet_pu #(
  parameter int          N        = 4,
  parameter int          DATA_W   = 16,
  parameter int          FRAC_W   = 8,
  parameter int unsigned EPS      = 32'h0000_0020,
  parameter int          MAX_ITER = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N*DATA_W-1:0]           in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N*DATA_W-1:0]           out_data,
  output logic [$clog2(N)-1:0]          winner_idx,
  output logic                          winner_valid,
  output logic                          timeout,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

  localparam int IDX_W  = $clog2(N);
  localparam int IT_W   = $clog2(MAX_ITER + 1);
  localparam int CNT_W  = $clog2(N + 1);
  localparam int ACC_W  = DATA_W + IDX_W;
  localparam int PROD_W = ACC_W + DATA_W;
  localparam logic [DATA_W-1:0] EPS_Q = DATA_W'(EPS);

  typedef enum logic [2:0] {IDLE, SUM, UPDATE, CHECK, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] x [N];
  logic [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]  sum_idx;
  logic [CNT_W-1:0]  nz_cnt;
  logic [IDX_W-1:0]  nz_idx;

  // Channels are never negative after the load clamp, so S - x_i cannot
  // underflow and the whole inhibition path can stay unsigned.
  function automatic logic [DATA_W-1:0] inhibit(input logic [DATA_W-1:0] xi,
                                                input logic [ACC_W-1:0]  s);
    logic [PROD_W-1:0] t;
    t = (PROD_W'(s - ACC_W'(xi)) * PROD_W'(EPS_Q)) >> FRAC_W;
    return (PROD_W'(xi) > t) ? xi - t[DATA_W-1:0] : '0;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign out_data[g*DATA_W +: DATA_W] = x[g];
  end

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    nz_cnt = '0;
    nz_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (x[i] != '0) begin
        nz_cnt = nz_cnt + CNT_W'(1);
        nz_idx = IDX_W'(i);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      acc          <= '0;
      sum_idx      <= '0;
      winner_idx   <= '0;
      winner_valid <= 1'b0;
      timeout      <= 1'b0;
      iter_count   <= '0;
      // NOTE: the channel array is small and drives out_data, so it is reset
      // like any other register rather than left to power-up contents.
      for (int i = 0; i < N; i++) x[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N; i++)
              x[i] <= in_data[i*DATA_W + DATA_W - 1] ? '0 : in_data[i*DATA_W +: DATA_W];
            acc          <= '0;
            sum_idx      <= '0;
            iter_count   <= '0;
            winner_idx   <= '0;
            winner_valid <= 1'b0;
            timeout      <= 1'b0;
            in_ready     <= 1'b0;
            state        <= SUM;
          end
        end
        SUM: begin
          acc <= acc + ACC_W'(x[sum_idx]);
          if (sum_idx == IDX_W'(N - 1)) begin
            sum_idx <= '0;
            state   <= UPDATE;
          end else begin
            sum_idx <= sum_idx + IDX_W'(1);
          end
        end
        UPDATE: begin
          for (int i = 0; i < N; i++) x[i] <= inhibit(x[i], acc);
          iter_count <= iter_count + IT_W'(1);
          state      <= CHECK;
        end
        CHECK: begin
          if (nz_cnt <= CNT_W'(1)) begin
            winner_valid <= (nz_cnt == CNT_W'(1));
            winner_idx   <= nz_idx;
            timeout      <= 1'b0;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else if (iter_count == IT_W'(MAX_ITER)) begin
            winner_valid <= 1'b0;
            winner_idx   <= '0;
            timeout      <= 1'b1;
            out_valid    <= 1'b1;
            state        <= DONE;
          end else begin
            acc   <= '0;
            state <= SUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_pu.sv
// Directed bench for maxnet_pu: three instances (default, short MAX_ITER, wide)
// sharing one driver, with expected results queued at stimulus and popped at output.
module tb_maxnet_pu;

  typedef struct {
    logic [191:0] data;
    int           idx;
    bit           wv;
    bit           to;
    int           iter;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  exp_t         sb[$];

  int           sel;
  logic         drv_valid;
  logic         drv_ready;
  logic [191:0] drv_data;

  logic         in_ready_a, out_valid_a, winner_valid_a, timeout_a;
  logic [63:0]  out_data_a;
  logic [1:0]   winner_idx_a;
  logic [5:0]   iter_count_a;

  logic         in_ready_b, out_valid_b, winner_valid_b, timeout_b;
  logic [63:0]  out_data_b;
  logic [1:0]   winner_idx_b;
  logic [2:0]   iter_count_b;

  logic         in_ready_c, out_valid_c, winner_valid_c, timeout_c;
  logic [191:0] out_data_c;
  logic [2:0]   winner_idx_c;
  logic [5:0]   iter_count_c;

  maxnet_pu u_a (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid && sel == 0), .in_ready(in_ready_a), .in_data(drv_data[63:0]),
    .out_valid(out_valid_a), .out_ready(drv_ready && sel == 0), .out_data(out_data_a),
    .winner_idx(winner_idx_a), .winner_valid(winner_valid_a), .timeout(timeout_a),
    .iter_count(iter_count_a)
  );

  maxnet_pu #(.MAX_ITER(4)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid && sel == 1), .in_ready(in_ready_b), .in_data(drv_data[63:0]),
    .out_valid(out_valid_b), .out_ready(drv_ready && sel == 1), .out_data(out_data_b),
    .winner_idx(winner_idx_b), .winner_valid(winner_valid_b), .timeout(timeout_b),
    .iter_count(iter_count_b)
  );

  maxnet_pu #(.N(8), .DATA_W(24), .FRAC_W(12), .EPS(32'h0000_0200)) u_c (
    .clk(clk), .rst(rst),
    .in_valid(drv_valid && sel == 2), .in_ready(in_ready_c), .in_data(drv_data),
    .out_valid(out_valid_c), .out_ready(drv_ready && sel == 2), .out_data(out_data_c),
    .winner_idx(winner_idx_c), .winner_valid(winner_valid_c), .timeout(timeout_c),
    .iter_count(iter_count_c)
  );

  logic         cur_in_ready, cur_out_valid, cur_wv, cur_to;
  logic [191:0] cur_data;
  int           cur_idx, cur_iter;

  always_comb begin
    cur_in_ready  = in_ready_a;
    cur_out_valid = out_valid_a;
    cur_data      = 192'(out_data_a);
    cur_idx       = int'(winner_idx_a);
    cur_wv        = winner_valid_a;
    cur_to        = timeout_a;
    cur_iter      = int'(iter_count_a);
    if (sel == 1) begin
      cur_in_ready  = in_ready_b;
      cur_out_valid = out_valid_b;
      cur_data      = 192'(out_data_b);
      cur_idx       = int'(winner_idx_b);
      cur_wv        = winner_valid_b;
      cur_to        = timeout_b;
      cur_iter      = int'(iter_count_b);
    end else if (sel == 2) begin
      cur_in_ready  = in_ready_c;
      cur_out_valid = out_valid_c;
      cur_data      = out_data_c;
      cur_idx       = int'(winner_idx_c);
      cur_wv        = winner_valid_c;
      cur_to        = timeout_c;
      cur_iter      = int'(iter_count_c);
    end
  end

  function automatic logic [191:0] pack4(input int c0, input int c1, input int c2, input int c3);
    logic [191:0] r;
    r = '0;
    r[0  +: 16] = 16'(c0);
    r[16 +: 16] = 16'(c1);
    r[32 +: 16] = 16'(c2);
    r[48 +: 16] = 16'(c3);
    return r;
  endfunction

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drives one vector; returns just after the accepting edge (latency count 1).
  task automatic accept(input logic [191:0] v);
    drv_data  = v;
    drv_valid = 1'b1;
    check("accept_in_ready", cur_in_ready, 1);
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!cur_out_valid && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic score(input string tag, input int lat);
    exp_t e;
    check({tag, "_out_valid"}, cur_out_valid, 1);
    if (sb.size() == 0) begin
      $display("FAIL %s: scoreboard empty, got data %0h", tag, cur_data);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    check({tag, "_data"},    cur_data, e.data);
    check({tag, "_idx"},     cur_idx,  e.idx);
    check({tag, "_wv"},      cur_wv,   e.wv);
    check({tag, "_timeout"}, cur_to,   e.to);
    check({tag, "_iter"},    cur_iter, e.iter);
    check({tag, "_latency"}, lat,      e.lat);
  endtask

  task automatic release_out(input string tag);
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    check({tag, "_rel_in_ready"},  cur_in_ready,  1);
    check({tag, "_rel_out_valid"}, cur_out_valid, 0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [191:0] v;
    sel       = 0;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_data  = '0;

    // Reset values, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready",  cur_in_ready,  1);
    check("rst_out_valid", cur_out_valid, 0);
    check("rst_data",      cur_data,      0);
    check("rst_idx",       cur_idx,       0);
    check("rst_wv",        cur_wv,        0);
    check("rst_timeout",   cur_to,        0);
    check("rst_iter",      cur_iter,      0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic winner, with a look at the channels after the first update.
    sb.push_back('{data: pack4(207, 0, 0, 0), idx: 0, wv: 1'b1, to: 1'b0, iter: 5, lat: 31});
    accept(pack4(256, 128, 64, 32));
    repeat (5) begin @(posedge clk); #1; end
    check("t1_iter1_data", cur_data, pack4(228, 84, 12, 0));
    check("t1_iter1_cnt",  cur_iter, 1);
    check("t1_busy",       cur_in_ready, 0);
    wait_out(6, lat);
    score("t1", lat);
    release_out("t1");

    // Negative clamp, then held in DONE under backpressure with in_valid pulses.
    sb.push_back('{data: pack4(0, 256, 0, 0), idx: 1, wv: 1'b1, to: 1'b0, iter: 1, lat: 7});
    accept(pack4('hFF00, 'h0100, 0, 0));
    wait_out(1, lat);
    score("t2", lat);
    for (int i = 0; i < 10; i++) begin
      drv_data  = pack4(1, 2, 3, 4);
      drv_valid = i[0];
      @(posedge clk); #1;
      check("t4_hold_valid", cur_out_valid, 1);
      check("t4_in_ready",   cur_in_ready,  0);
      check("t4_hold_data",  cur_data,      pack4(0, 256, 0, 0));
      check("t4_hold_idx",   cur_idx,       1);
    end
    drv_valid = 1'b0;
    release_out("t4");

    // All-zero load still runs exactly one iteration.
    sb.push_back('{data: '0, idx: 0, wv: 1'b0, to: 1'b0, iter: 1, lat: 7});
    accept('0);
    wait_out(1, lat);
    score("t_zero", lat);
    release_out("t_zero");

    // Reset during the second SUM pass of the basic-winner vector.
    accept(pack4(256, 128, 64, 32));
    repeat (7) begin @(posedge clk); #1; end
    check("t5_mid_iter", cur_iter,     1);
    check("t5_mid_busy", cur_in_ready, 0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_in_ready",  cur_in_ready,  1);
    check("t5_rst_out_valid", cur_out_valid, 0);
    check("t5_rst_data",      cur_data,      0);
    check("t5_rst_iter",      cur_iter,      0);
    check("t5_rst_wv",        cur_wv,        0);
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (cur_out_valid) seen++;
    end
    check("t5_no_out_valid", seen, 0);
    sb.push_back('{data: pack4(0, 0, 768, 0), idx: 2, wv: 1'b1, to: 1'b0, iter: 1, lat: 7});
    accept(pack4(0, 0, 'h0300, 'hFFFF));
    wait_out(1, lat);
    score("t5_after", lat);
    release_out("t5_after");

    // Exact tie on the MAX_ITER=4 instance ends by timeout.
    sel = 1;
    sb.push_back('{data: pack4(40, 40, 40, 40), idx: 0, wv: 1'b0, to: 1'b1, iter: 4, lat: 25});
    accept(pack4(256, 256, 256, 256));
    wait_out(1, lat);
    score("t3", lat);
    release_out("t3");

    // Wide instance: eight 24-bit channels, only channel 5 non-zero.
    sel = 2;
    v = '0;
    v[5*24 +: 24] = 24'h001000;
    sb.push_back('{data: v, idx: 5, wv: 1'b1, to: 1'b0, iter: 1, lat: 11});
    accept(v);
    wait_out(1, lat);
    score("t6", lat);
    release_out("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/maxnet_pu.md
Name: maxnet_pu

Overview:
- Parametrised successor to the fixed 4-input processing unit.
- Implements an N-channel MaxNet winner-take-all layer on signed fixed-point activations.
- Loads a vector, then iterates x_i <- ReLU(x_i - EPS*(sum of other channels)) until at most one channel is non-zero or MAX_ITER is reached.
- Sits after the neuron output stage and reports the surviving channel.

Parameters:
- N, 4, channel count (>=2).
- DATA_W, 16, signed activation width.
- FRAC_W, 8, fractional bits of activations and EPS.
- EPS, 16'h0020, inhibition weight, unsigned, same Q format (0.125 at default).
- MAX_ITER, 32, iteration limit (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N*DATA_W  packed activations; channel i at bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  N*DATA_W  final activations, same packing.
- winner_idx  out  clog2(N)  index of the sole non-zero channel; 0 if none.
- winner_valid  out  1  exactly one channel non-zero at finish.
- timeout  out  1  finished because MAX_ITER was reached.
- iter_count  out  clog2(MAX_ITER+1)  iterations executed.

Behaviour:
- Clock/reset: one clock domain; reset is asynchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, all data regs 0, winner_idx=0, winner_valid=0, timeout=0, iter_count=0.
- Reset asserted in any state aborts the operation immediately; no partial result is emitted.
- States: IDLE, SUM, UPDATE, CHECK, DONE.
- IDLE:
  - in_ready=1.
  - A cycle with in_valid=1 latches in_data with ReLU applied (negative -> 0), clears the accumulator, sets iter_count=0, goes to SUM.
- SUM:
  - N cycles; adds one channel per cycle (index 0..N-1) into accumulator S.
  - S width is DATA_W+clog2(N), unsigned.
- UPDATE:
  - 1 cycle; all channels update in parallel.
  - t_i = ((S - x_i) * EPS) >> FRAC_W, logical shift, truncating.
  - x_i <- max(x_i - t_i, 0), computed at full width, no wrap.
  - iter_count increments.
- CHECK:
  - 1 cycle; counts non-zero channels.
  - count<=1: winner_valid=(count==1), winner_idx=index of the non-zero channel (0 if none), timeout=0, go to DONE.
  - Otherwise, iter_count==MAX_ITER: timeout=1, winner_valid=0, winner_idx=0, go to DONE.
  - Otherwise: clear S, go to SUM.
- At least one iteration always runs, even if the loaded vector already has <=1 non-zero channel.
- Iteration latency: N+2 cycles. Total latency from accept to out_valid: 1 + k*(N+2) cycles for k iterations.
- DONE:
  - out_valid=1; out_data and the flags are held stable while out_ready=0.
  - A cycle with out_ready=1 returns to IDLE; out_valid drops the next cycle.
  - No same-cycle re-accept: in_ready is 0 in DONE.
- Busy behaviour: in_ready=0 in SUM, UPDATE, CHECK and DONE; in_valid is ignored there and in_data is not sampled.
- All-zero load: runs one iteration, ends with winner_valid=0, timeout=0, iter_count=1.

Test Plan:
Defaults unless stated: N=4, DATA_W=16, FRAC_W=8, EPS=0x0020.
1. Basic winner: in_data ch0..3 = 256, 128, 64, 32.
   - After iteration 1: out regs {228, 84, 12, 0}.
   - Final: out_data {207, 0, 0, 0}, winner_idx=0, winner_valid=1, timeout=0, iter_count=5, out_valid 31 cycles after accept.
2. Negative clamp: ch0..3 = 0xFF00, 0x0100, 0, 0 -> out_data {0, 256, 0, 0}, winner_idx=1, winner_valid=1, iter_count=1.
3. Tie with MAX_ITER=4: all channels 0x0100 -> timeout=1, winner_valid=0, winner_idx=0, iter_count=4, all four channels equal and non-zero.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE.
   - out_valid and outputs stay stable; in_valid pulses are ignored (in_ready=0).
   - out_ready=1 -> IDLE, in_ready=1 next cycle.
5. Reset mid-run: assert rst during the 2nd SUM of case 1.
   - Outputs return to reset values asynchronously; no out_valid.
   - A new vector is accepted after rst deasserts.
6. Parametric: N=8, DATA_W=24, FRAC_W=12, EPS=0x000200 (0.125), single non-zero ch5=0x001000, rest 0.
   - winner_idx=5, out ch5=0x001000, iter_count=1, latency 1+10 cycles.
